// File: rtl/layer_feeder.sv
// Layer sequencer: streams (activation, weight, bias) terms of each node into node_op
// and writes the returned x into the result buffer. Optional macro: RELU_EN (ReLU on write-back).
module layer_feeder #(
  parameter int N_INPUTS = 16,
  parameter int N_NODES  = 8,
  parameter int DATA_W   = 16,
  parameter int AW_A     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
  parameter int AW_W     = (N_INPUTS * N_NODES > 1) ? $clog2(N_INPUTS * N_NODES) : 1,
  parameter int AW_N     = (N_NODES > 1) ? $clog2(N_NODES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [AW_A-1:0]   act_addr,
  input  logic [DATA_W-1:0] act_rdata,
  output logic [AW_W-1:0]   w_addr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic [AW_N-1:0]   b_addr,
  input  logic [DATA_W-1:0] b_rdata,
  output logic              node_valid_in,
  output logic [DATA_W-1:0] node_prev_output,
  output logic [DATA_W-1:0] node_weight,
  output logic [DATA_W-1:0] node_bias,
  output logic              node_last,
  input  logic              node_valid_out,
  input  logic [DATA_W-1:0] node_x,
  output logic              res_we,
  output logic [AW_N-1:0]   res_addr,
  output logic [DATA_W-1:0] res_wdata
);

  typedef enum logic [2:0] {IDLE, ISSUE, STREAM, WAIT_X, WRITE, FIN} state_t;

  localparam logic [AW_A-1:0] I_MAX  = AW_A'(N_INPUTS - 1);
  localparam logic [AW_N-1:0] N_MAX  = AW_N'(N_NODES - 1);
  localparam logic [AW_W-1:0] N_IN_W = AW_W'(N_INPUTS);

  state_t            state_q, state_d;
  logic [AW_A-1:0]   i_q, i_d;
  logic [AW_N-1:0]   n_q, n_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] wt_q, wt_d;
  logic [DATA_W-1:0] bias_q, bias_d;
  logic              term_en;
  logic [AW_A-1:0]   rd_idx;
  logic [DATA_W-1:0] wb_data;

  // STREAM spends one extra cycle presenting the registered last term, so
  // valid_in is already low once WAIT_X is entered.
  assign term_en = (state_q == STREAM) && !last_q;

`ifdef RELU_EN
  assign wb_data = x_q[DATA_W-1] ? '0 : x_q;
`else
  assign wb_data = x_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      n_q     <= '0;
      x_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      prev_q  <= '0;
      wt_q    <= '0;
      bias_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      n_q     <= n_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      prev_q  <= prev_d;
      wt_q    <= wt_d;
      bias_q  <= bias_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    n_d     = n_q;
    x_d     = x_q;
    case (state_q)
      IDLE:   if (start) state_d = ISSUE;
      ISSUE:  state_d = STREAM;
      STREAM: begin
        if (last_q) state_d = WAIT_X;
        else        i_d = (i_q == I_MAX) ? '0 : i_q + AW_A'(1);
      end
      WAIT_X: begin
        if (node_valid_out) begin
          x_d     = node_x;
          state_d = WRITE;
        end
      end
      WRITE: begin
        i_d = '0;
        if (n_q == N_MAX) begin
          n_d     = '0;
          state_d = FIN;
        end else begin
          n_d     = n_q + AW_N'(1);
          state_d = ISSUE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_d = term_en;
    last_d  = term_en && (i_q == I_MAX);
    prev_d  = term_en ? act_rdata : '0;
    wt_d    = term_en ? w_rdata   : '0;
    bias_d  = term_en ? b_rdata   : '0;
  end

  always_comb begin
    busy      = (state_q == ISSUE) || (state_q == STREAM) ||
                (state_q == WAIT_X) || (state_q == WRITE);
    done      = (state_q == FIN);
    res_we    = (state_q == WRITE);
    res_addr  = res_we ? n_q : '0;
    res_wdata = res_we ? wb_data : '0;
    // Read address runs one term ahead of the data being registered.
    rd_idx    = '0;
    if (term_en && (i_q != I_MAX)) rd_idx = i_q + AW_A'(1);
    act_addr  = rd_idx;
    w_addr    = AW_W'(n_q) * N_IN_W + AW_W'(rd_idx);
    b_addr    = n_q;
  end

  assign node_valid_in    = valid_q;
  assign node_last        = last_q;
  assign node_prev_output = prev_q;
  assign node_weight      = wt_q;
  assign node_bias        = bias_q;

endmodule

// File: tb/tb_layer_feeder.sv
// Directed bench for layer_feeder (4 inputs, 2 nodes) with a 3-cycle node_op model.
module tb_layer_feeder;
  localparam int NI = 4, NN = 2, DW = 16, AWA = 2, AWW = 3, AWN = 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, node_valid_in, node_last, node_valid_out, res_we;
  logic [AWA-1:0] act_addr;
  logic [AWW-1:0] w_addr;
  logic [AWN-1:0] b_addr, res_addr;
  logic [DW-1:0] act_rdata, w_rdata, b_rdata, node_prev_output, node_weight, node_bias, node_x, res_wdata;

  always #5 clk = ~clk;

  layer_feeder #(.N_INPUTS(NI), .N_NODES(NN), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .act_addr(act_addr), .act_rdata(act_rdata), .w_addr(w_addr), .w_rdata(w_rdata),
    .b_addr(b_addr), .b_rdata(b_rdata), .node_valid_in(node_valid_in),
    .node_prev_output(node_prev_output), .node_weight(node_weight), .node_bias(node_bias),
    .node_last(node_last), .node_valid_out(node_valid_out), .node_x(node_x),
    .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata)
  );

`ifdef RELU_EN
  localparam logic [DW-1:0] EXP_X1 = 16'h0000;
`else
  localparam logic [DW-1:0] EXP_X1 = 16'hFFF0;
`endif

  logic [DW-1:0] act_mem [NI];
  logic [DW-1:0] w_mem   [NI*NN];
  logic [DW-1:0] b_mem   [NN];
  logic [DW-1:0] x_tab   [NN];

  always @(posedge clk) begin
    act_rdata <= act_mem[act_addr];
    w_rdata   <= w_mem[w_addr];
    b_rdata   <= b_mem[b_addr];
  end

  // node_op model: result 3 cycles after the node_last term
  int   lat_cnt = 0, node_idx = 0;
  logic spur_en = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      lat_cnt  <= 0;
      node_idx <= 0;
    end else begin
      if (node_valid_in && node_last) lat_cnt <= 3;
      else if (lat_cnt > 0)          lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) node_idx <= (node_idx + 1) % NN;
    end
  end
  assign node_valid_out = (lat_cnt == 1) || (spur_en && node_valid_in && !node_last);
  assign node_x         = (lat_cnt == 1) ? x_tab[node_idx] : 16'h1234;

  int tcnt = 0, rcnt = 0, dcnt = 0, negcnt = 0, last_res_neg = 0, done_neg = 0;
  logic [DW-1:0]  t_prev [64], t_w [64], t_b [64], r_data [16];
  logic           t_last [64];
  logic [AWN-1:0] r_addr [16];
  always @(negedge clk) begin
    negcnt <= negcnt + 1;
    if (node_valid_in && tcnt < 64) begin
      t_prev[tcnt] <= node_prev_output;
      t_w[tcnt]    <= node_weight;
      t_b[tcnt]    <= node_bias;
      t_last[tcnt] <= node_last;
      tcnt         <= tcnt + 1;
    end
    if (res_we && rcnt < 16) begin
      r_addr[rcnt] <= res_addr;
      r_data[rcnt] <= res_wdata;
      rcnt         <= rcnt + 1;
      last_res_neg <= negcnt;
    end
    if (done) begin
      dcnt     <= dcnt + 1;
      done_neg <= negcnt;
    end
  end

  int n_checks = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_valid"}, node_valid_in, 0);
    check({tag, "_last"}, node_last, 0);
    check({tag, "_res_we"}, res_we, 0);
    check({tag, "_act_addr"}, act_addr, 0);
    check({tag, "_w_addr"}, w_addr, 0);
    check({tag, "_b_addr"}, b_addr, 0);
    check({tag, "_res_addr"}, res_addr, 0);
    check({tag, "_res_wdata"}, res_wdata, 0);
    check({tag, "_prev"}, node_prev_output, 0);
    check({tag, "_weight"}, node_weight, 0);
    check({tag, "_bias"}, node_bias, 0);
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, ok, 1);
    check({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic check_terms(input string tag, input int base);
    for (int k = 0; k < NI*NN; k++) begin
      check($sformatf("%s_w%0d", tag, k), t_w[base+k], k);
      check($sformatf("%s_act%0d", tag, k), t_prev[base+k], act_mem[k%NI]);
      check($sformatf("%s_bias%0d", tag, k), t_b[base+k], (k/NI == 0) ? 10 : 20);
      check($sformatf("%s_last%0d", tag, k), t_last[base+k], (k%NI == NI-1) ? 1 : 0);
    end
  endtask

  task automatic check_results(input string tag, input int base);
    check({tag, "_res0_addr"}, r_addr[base], 0);
    check({tag, "_res0_data"}, r_data[base], 16'h0050);
    check({tag, "_res1_addr"}, r_addr[base+1], 1);
    check({tag, "_res1_data"}, r_data[base+1], EXP_X1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tb0, rb0, db0;
    bit seen;
    for (int k = 0; k < NI; k++) act_mem[k] = 16'(k + 1);
    for (int k = 0; k < NI*NN; k++) w_mem[k] = 16'(k);
    b_mem[0] = 16'd10; b_mem[1] = 16'd20;
    x_tab[0] = 16'h0050; x_tab[1] = 16'hFFF0;

    // 1: reset with start held alongside it
    rst = 1; start = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0; start = 0;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    check("reset_start_ignored", busy, 0);
    $display("reset: done");

    // 2-4: one full pass
    tb0 = tcnt; rb0 = rcnt; db0 = dcnt;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    check("p1_busy_issue", busy, 1);
    check("p1_valid_issue", node_valid_in, 0);
    @(negedge clk);
    check("p1_valid_start1", node_valid_in, 0);
    @(negedge clk);
    check("p1_valid_start2", node_valid_in, 1);
    check("p1_first_weight", node_weight, 0);
    wait_done("p1");
    repeat (3) @(posedge clk);
    check("p1_term_count", tcnt - tb0, NI*NN);
    check("p1_res_count", rcnt - rb0, 2);
    check("p1_done_count", dcnt - db0, 1);
    check("p1_done_after_res", done_neg - last_res_neg, 1);
    check_terms("p1", tb0);
    check_results("p1", rb0);
    $display("pass1: res0=0x%0h res1=0x%0h", r_data[rb0], r_data[rb0+1]);

    // 5: start held high, spurious node_valid_out during STREAM
    tb0 = tcnt; rb0 = rcnt; db0 = dcnt;
    spur_en = 1;
    @(negedge clk); start = 1;
    wait_done("p2a");
    @(negedge clk);
    check("p2_idle_gap_busy", busy, 0);
    @(negedge clk);
    check("p2_restart_busy", busy, 1);
    start = 0;
    wait_done("p2b");
    repeat (3) @(posedge clk);
    spur_en = 0;
    check("p2_term_count", tcnt - tb0, 2*NI*NN);
    check("p2_res_count", rcnt - rb0, 4);
    check("p2_done_count", dcnt - db0, 2);
    check_results("p2a", rb0);
    check_results("p2b", rb0 + 2);
    $display("pass2: two back-to-back passes, res_we count=%0d", rcnt - rb0);

    // 6: reset during STREAM of node 1, then a clean pass
    tb0 = tcnt; rb0 = rcnt; db0 = dcnt;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (node_valid_in && node_bias == 16'd20) begin
        seen = 1;
        break;
      end
    end
    check("p3_node1_stream_seen", seen, 1);
    rst = 1;
    @(negedge clk);
    check_idle_outputs("midreset");
    rst = 0;
    repeat (10) @(negedge clk);
    check("midreset_no_done", dcnt - db0, 0);
    check("midreset_partial_res", rcnt - rb0, 1);
    check("midreset_still_idle", busy, 0);
    tb0 = tcnt; rb0 = rcnt; db0 = dcnt;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    wait_done("p4");
    repeat (3) @(posedge clk);
    check("p4_term_count", tcnt - tb0, NI*NN);
    check("p4_res_count", rcnt - rb0, 2);
    check("p4_done_count", dcnt - db0, 1);
    check_terms("p4", tb0);
    check_results("p4", rb0);
    $display("pass4: clean pass after mid-pass reset, res1=0x%0h", r_data[rb0+1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
